// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the single regfile write port. Each source has a
// one-entry buffer; grants are round-robin, oldest-first on same-register collisions.
module regfile_wb_arbiter #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    ReqValidA,
  input  logic [ADDR_BITS-1:0]    ReqRegA,
  input  logic [WIDTH-1:0]        ReqDataA,
  output logic                    ReqReadyA,
  input  logic                    ReqValidB,
  input  logic [ADDR_BITS-1:0]    ReqRegB,
  input  logic [WIDTH-1:0]        ReqDataB,
  output logic                    ReqReadyB,
  output logic                    RegWrite,
  output logic [ADDR_BITS-1:0]    WriteRegister,
  output logic [WIDTH-1:0]        WriteData,
  output logic [2**ADDR_BITS-1:0] Pending
);
  localparam int NREGS = 2**ADDR_BITS;

  typedef struct packed {
    logic [ADDR_BITS-1:0] rd;
    logic [WIDTH-1:0]     data;
  } wb_ent_t;

  logic    full_a_q, full_a_d, full_b_q, full_b_d;
  wb_ent_t ent_a_q, ent_a_d, ent_b_q, ent_b_d;
  logic    older_a_q, older_a_d;
  logic    last_b_q, last_b_d;
  logic    grant_a, grant_b, load_a, load_b;

  always_comb begin
    grant_a = full_a_q;
    if (full_a_q && full_b_q)
      grant_a = (ent_a_q.rd == ent_b_q.rd) ? older_a_q : last_b_q;
    grant_b = full_b_q & ~grant_a;
  end

  assign ReqReadyA = ~full_a_q | grant_a;
  assign ReqReadyB = ~full_b_q | grant_b;

  // Register-0 writes are accepted but never buffered.
  assign load_a = ReqValidA & ReqReadyA & (|ReqRegA);
  assign load_b = ReqValidB & ReqReadyB & (|ReqRegB);

  always_comb begin
    full_a_d  = load_a | (full_a_q & ~grant_a);
    full_b_d  = load_b | (full_b_q & ~grant_b);
    ent_a_d   = load_a ? '{rd: ReqRegA, data: ReqDataA} : ent_a_q;
    ent_b_d   = load_b ? '{rd: ReqRegB, data: ReqDataB} : ent_b_q;
    // A freshly loaded entry is younger than whatever the other buffer keeps.
    older_a_d = older_a_q;
    if (load_a && load_b) older_a_d = 1'b1;
    else if (load_a)      older_a_d = 1'b0;
    else if (load_b)      older_a_d = 1'b1;
    last_b_d  = grant_b ? 1'b1 : (grant_a ? 1'b0 : last_b_q);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      full_a_q  <= 1'b0;
      full_b_q  <= 1'b0;
      ent_a_q   <= '0;
      ent_b_q   <= '0;
      older_a_q <= 1'b0;
      last_b_q  <= 1'b1;
    end else begin
      full_a_q  <= full_a_d;
      full_b_q  <= full_b_d;
      ent_a_q   <= ent_a_d;
      ent_b_q   <= ent_b_d;
      older_a_q <= older_a_d;
      last_b_q  <= last_b_d;
    end
  end

  always_comb begin
    RegWrite      = grant_a | grant_b;
    WriteRegister = '0;
    WriteData     = '0;
    if (grant_a) begin
      WriteRegister = ent_a_q.rd;
      WriteData     = ent_a_q.data;
    end else if (grant_b) begin
      WriteRegister = ent_b_q.rd;
      WriteData     = ent_b_q.data;
    end
  end

  assign Pending[0] = 1'b0;
  for (genvar r = 1; r < NREGS; r++) begin : g_pend
    assign Pending[r] = (full_a_q && ent_a_q.rd == ADDR_BITS'(r)) ||
                        (full_b_q && ent_b_q.rd == ADDR_BITS'(r));
  end
endmodule
